// File: rtl/alu_pkg.sv
// Shared ALU op codes and NZCV flag layout for the execute stage.
package alu_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned FLAGS_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_ORR = 4'b0011,
        OP_EOR = 4'b0100,
        OP_ADC = 4'b0101,
        OP_SBC = 4'b0110,
        OP_LSL = 4'b0111,
        OP_LSR = 4'b1000,
        OP_ASR = 4'b1001,
        OP_MUL = 4'b1010
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier; first partial product is taken at start,
// done flags the cycle in which product_lo already includes the final bit.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product_lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_step;
    logic [CNT_W-1:0] cnt;

    assign acc_step   = acc + (mplier[0] ? mcand : '0);
    assign done       = (cnt == CNT_W'(1));
    assign product_lo = acc_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
            cnt    <= CNT_W'(WIDTH - 1);
        end else if (cnt != '0) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Handshaked execute-stage ALU with internal NZCV register and iterative MUL.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output alu_flags_t       flags
);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;

    state_t             state, state_n;
    logic               accept, load_alu, mul_start, mul_done, mul_sf;
    logic [WIDTH-1:0]   mul_prod;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_err;
    alu_flags_t         alu_flags, mul_flags;
    logic [SHAMT_W-1:0] sh;
    logic [WIDTH-1:0]   bx;
    logic               cin;
    logic [WIDTH:0]     sum, shl, shr, sar;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start      (mul_start),
        .a          (a),
        .b          (b),
        .done       (mul_done),
        .product_lo (mul_prod)
    );

    // Subtraction is a + ~b + cin, so C comes out as NOT borrow directly.
    always_comb begin
        sh  = b[SHAMT_W-1:0];
        bx  = ((op == OP_SUB) || (op == OP_SBC)) ? ~b : b;
        cin = 1'b0;
        if (op == OP_SUB)                         cin = 1'b1;
        if ((op == OP_ADC) || (op == OP_SBC))     cin = flags.c;
        sum = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(cin);
        // Extra guard bit on each shift captures the last bit shifted out.
        shl = {1'b0, a} << sh;
        shr = {a, 1'b0} >> sh;
        sar = $signed({a, 1'b0}) >>> sh;

        alu_res   = '0;
        alu_err   = 1'b0;
        alu_flags = flags;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                alu_res     = sum[WIDTH-1:0];
                alu_flags.c = sum[WIDTH];
                alu_flags.v = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_ORR: alu_res = a | b;
            OP_EOR: alu_res = a ^ b;
            OP_LSL: begin
                alu_res = shl[WIDTH-1:0];
                if (sh != '0) alu_flags.c = shl[WIDTH];
            end
            OP_LSR: begin
                alu_res = shr[WIDTH:1];
                if (sh != '0) alu_flags.c = shr[0];
            end
            OP_ASR: begin
                alu_res = sar[WIDTH:1];
                if (sh != '0) alu_flags.c = sar[0];
            end
            OP_MUL:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase
        alu_flags.n = alu_res[WIDTH-1];
        alu_flags.z = (alu_res == '0);

        mul_flags   = flags;
        mul_flags.n = mul_prod[WIDTH-1];
        mul_flags.z = (mul_prod == '0);
    end

    always_comb begin
        state_n   = state;
        load_alu  = 1'b0;
        mul_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_n   = MUL_BUSY;
                    end else begin
                        load_alu  = 1'b1;
                        state_n   = DONE;
                    end
                end else if ((state == DONE) && out_ready) begin
                    state_n = IDLE;
                end
            end
            MUL_BUSY: if (mul_done) state_n = DONE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            err    <= 1'b0;
            flags  <= '0;
            mul_sf <= 1'b0;
        end else begin
            state <= state_n;
            if (mul_start) mul_sf <= set_flags;
            if (load_alu) begin
                result <= alu_res;
                err    <= alu_err;
                if (set_flags && !alu_err) flags <= alu_flags;
            end else if ((state == MUL_BUSY) && mul_done) begin
                result <= mul_prod;
                err    <= 1'b0;
                if (mul_sf) flags <= mul_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed and randomized checks of alu_seq_exec against an arithmetic reference model.
module tb_alu_seq_exec
    import alu_pkg::*;
;
    localparam int unsigned W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, set_flags, out_valid, out_ready, err;
    alu_op_t      op;
    logic [W-1:0] a, b, result;
    alu_flags_t   flags;

    int           errors = 0;
    int           checks = 0;
    logic [3:0]   mflags;

    always #5 clk = ~clk;

    alu_seq_exec #(.WIDTH(W), .SHAMT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: flags as {N,Z,C,V}; arithmetic done in 64-bit integers.
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic sf, input logic [3:0] fi,
                                  output logic [31:0] r, output logic e, output logic [3:0] fo);
        longint     u, sd, ci;
        int         sh;
        logic       c, v;
        logic [63:0] p;
        c  = fi[1];
        v  = fi[0];
        e  = 1'b0;
        r  = '0;
        sh = int'(y[7:0]);
        case (o)
            4'h0, 4'h5: begin
                ci = (o == 4'h5 && fi[1]) ? 64'sd1 : 64'sd0;
                u  = longint'(x) + longint'(y) + ci;
                sd = longint'($signed(x)) + longint'($signed(y)) + ci;
                r  = u[31:0];
                c  = (u > 64'sd4294967295);
                v  = (sd > SMAX) || (sd < SMIN);
            end
            4'h1, 4'h6: begin
                ci = (o == 4'h6 && !fi[1]) ? 64'sd1 : 64'sd0;
                u  = longint'(x) - longint'(y) - ci;
                sd = longint'($signed(x)) - longint'($signed(y)) - ci;
                r  = u[31:0];
                c  = (u >= 0);
                v  = (sd > SMAX) || (sd < SMIN);
            end
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4: r = x ^ y;
            4'h7: begin
                if (sh == 0)      r = x;
                else if (sh < 32) begin r = x << sh; c = x[32-sh]; end
                else              begin r = '0; c = (sh == 32) ? x[0] : 1'b0; end
            end
            4'h8: begin
                if (sh == 0)      r = x;
                else if (sh < 32) begin r = x >> sh; c = x[sh-1]; end
                else              begin r = '0; c = (sh == 32) ? x[31] : 1'b0; end
            end
            4'h9: begin
                if (sh == 0)      r = x;
                else if (sh < 32) begin r = 32'($signed(x) >>> sh); c = x[sh-1]; end
                else              begin r = {32{x[31]}}; c = x[31]; end
            end
            4'hA: begin
                p = 64'(x) * 64'(y);
                r = p[31:0];
            end
            default: e = 1'b1;
        endcase
        fo = fi;
        if (sf && !e) fo = {r[31], (r == 32'd0), c, v};
    endfunction

    // Issue one op, wait a bounded time for the result, compare against the model.
    task automatic exec(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv, input logic sf);
        logic [31:0] er;
        logic        ee;
        logic [3:0]  ef;
        int          lat;
        model(o, av, bv, sf, mflags, er, ee, ef);
        op        = alu_op_t'(o);
        a         = av;
        b         = bv;
        set_flags = sf;
        in_valid  = 1'b1;
        chk("in_ready_at_issue", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("in_ready_while_busy", 32'(in_ready), 32'd0);
            step();
            lat++;
        end
        chk("latency", 32'(lat), (o == 4'hA) ? 32'd32 : 32'd1);
        chk("result", result, er);
        chk("err", 32'(err), 32'(ee));
        chk("flags", 32'(flags), 32'(ef));
        mflags = ef;
        if (out_ready) step();
    endtask

    initial begin
        logic [31:0] ra, rb, held;
        logic [31:0] q_res [4];
        logic        e_tmp;
        logic [3:0]  f_tmp;
        logic [3:0]  ro;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; set_flags = 1'b0;
        op = OP_ADD; a = '0; b = '0;
        mflags = 4'b0000;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Signed overflow on ADD.
        exec(4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        chk("add_ovf_nzcv", 32'(flags), 32'b1001);

        // SUB equal operands, then SBC with C set and cleared.
        exec(4'h1, 32'd5, 32'd5, 1'b1);
        chk("sub_eq_nzcv", 32'(flags), 32'b0110);
        exec(4'h6, 32'd0, 32'd0, 1'b1);
        exec(4'h6, 32'd0, 32'd1, 1'b1);
        exec(4'h6, 32'd0, 32'd0, 1'b1);
        chk("sbc_c0_result", result, 32'hFFFF_FFFF);

        // Shift boundaries.
        exec(4'h8, 32'h8000_0000, 32'd32, 1'b1);
        exec(4'h9, 32'h8000_0000, 32'd40, 1'b1);
        exec(4'h7, 32'h0000_0001, 32'd0, 1'b1);
        exec(4'h7, 32'h0000_0003, 32'd32, 1'b1);
        exec(4'h7, 32'hFFFF_FFFF, 32'd33, 1'b1);
        exec(4'h8, 32'h0000_00F0, 32'd5, 1'b1);

        // MUL with a stalled consumer.
        out_ready = 1'b0;
        exec(4'hA, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
        held = result;
        chk("mul_result", held, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_result", result, 32'hFFFF_FFFF);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("mul_drained", 32'(out_valid), 32'd0);

        // Reset in the middle of a MUL.
        op = OP_MUL; a = 32'h1234_5678; b = 32'h9ABC_DEF0; set_flags = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mflags = 4'b0000;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_flags", 32'(flags), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        exec(4'h0, 32'd2, 32'd3, 1'b1);
        chk("post_rst_add", result, 32'd5);

        // Illegal op leaves flags alone.
        exec(4'hF, 32'hDEAD_BEEF, 32'h1, 1'b1);

        // Four back-to-back ADDs, one result per cycle.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            model(4'h0, ra, rb, 1'b1, mflags, q_res[i], e_tmp, f_tmp);
            mflags = f_tmp;
            if (i > 0) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
                chk("b2b_result", result, q_res[i-1]);
                chk("b2b_err", 32'(err), 32'd0);
            end
            op = OP_ADD; a = ra; b = rb; set_flags = 1'b1; in_valid = 1'b1;
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_result", result, q_res[3]);
        chk("b2b_err", 32'(err), 32'd0);
        chk("b2b_flags", 32'(flags), 32'(mflags));
        step();

        // Randomized ops, biased so shift amounts often land near the width.
        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) rb[7:0] = 8'($urandom_range(0, 40));
            exec(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
